// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit serializer.
// Holds the frame width, the FSM state encodings and a small helper function.
package spi_pkg;

    localparam int SPI_DATA_W = 24;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE     = 3'd0;
    localparam spi_state_t ST_SETUP    = 3'd1;
    localparam spi_state_t ST_SHIFT_HI = 3'd2;
    localparam spi_state_t ST_SHIFT_LO = 3'd3;
    localparam spi_state_t ST_HOLD     = 3'd4;
    localparam spi_state_t ST_GAP      = 3'd5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous word FIFO with registered full/empty flags and a drop pulse.
// Ports: clk, rst (sync, active-high), push/wdata in, pop in, rdata out,
//        full/empty flags, overflow (one-cycle pulse when a push is dropped).
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push to a full FIFO
    // is still accepted when it coincides with a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_next;
            full     <= (count_next == (AW+1)'(DEPTH));
            empty    <= (count_next == '0);
            overflow <= push & full & ~do_pop;
        end
    end

endmodule

// File: rtl/spi_tx_serializer.sv
// Buffers write-strobed words and sends them as SPI mode-0 frames, MSB first.
// Ports: HCLK, HRESET (sync, active-high), tx_en/SPI_TX write strobe in;
//        fifo_full, fifo_empty, busy, overflow, frame_done status out;
//        spi_sclk, spi_mosi, spi_cs_n off-chip SPI pins out.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int DATA_W     = SPI_DATA_W,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_GAP     = 2
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              tx_en,
    input  logic [DATA_W-1:0] SPI_TX,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              busy,
    output logic              overflow,
    output logic              frame_done,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n
);

    // One counter times every phase, including the chip-select gap.
    localparam int CW = $clog2(max_int(CLK_DIV, CS_GAP)) + 1;
    localparam int BW = $clog2(DATA_W);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(DATA_W - 1);

    spi_state_t        state;
    logic [CW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] fifo_rdata;
    logic              pop;
    logic              div_last;
    logic              gap_last;

    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign div_last = (div_cnt == DIV_LAST);
    assign gap_last = (div_cnt == GAP_LAST);

    // MOSI is the shift register MSB, so it is a flop output and keeps
    // its last value between frames.
    assign spi_mosi = shreg[DATA_W-1];

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (HCLK),
        .rst      (HRESET),
        .push     (tx_en),
        .wdata    (SPI_TX),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            spi_sclk   <= 1'b0;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            div_cnt    <= div_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    div_cnt <= '0;
                    if (pop) begin
                        shreg    <= fifo_rdata;
                        bit_cnt  <= BIT_LOAD;
                        spi_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        state    <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b0;
                        // Last high phase goes straight to HOLD, no shift.
                        if (bit_cnt == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            shreg   <= {shreg[DATA_W-2:0], 1'b0};
                            state   <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        state    <= ST_SHIFT_HI;
                    end
                end
                ST_HOLD: begin
                    if (div_last) begin
                        div_cnt    <= '0;
                        spi_cs_n   <= 1'b1;
                        frame_done <= 1'b1;
                        state      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Self-checking bench for spi_tx_serializer.
// Pin-level frame monitor plus directed vector tables and corner sequences.
module tb_spi_tx_serializer;

    typedef struct {
        logic [23:0] data;
        int          nbits;
        int          len;
    } frame_t;

    typedef struct {
        logic [23:0] data;
        logic        full;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en0 = 1'b0;
    logic [23:0] data0 = '0;
    logic        tx_en1 = 1'b0;
    logic [23:0] data1 = '0;

    logic full0, empty0, busy0, ovf0, fd0, sclk0, mosi0, csn0;
    logic full1, empty1, busy1, ovf1, fd1, sclk1, mosi1, csn1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_tx_serializer u_dut0 (
        .HCLK       (clk),
        .HRESET     (rst),
        .tx_en      (tx_en0),
        .SPI_TX     (data0),
        .fifo_full  (full0),
        .fifo_empty (empty0),
        .busy       (busy0),
        .overflow   (ovf0),
        .frame_done (fd0),
        .spi_sclk   (sclk0),
        .spi_mosi   (mosi0),
        .spi_cs_n   (csn0)
    );

    spi_tx_serializer #(
        .CLK_DIV (1),
        .CS_GAP  (1)
    ) u_dut1 (
        .HCLK       (clk),
        .HRESET     (rst),
        .tx_en      (tx_en1),
        .SPI_TX     (data1),
        .fifo_full  (full1),
        .fifo_empty (empty1),
        .busy       (busy1),
        .overflow   (ovf1),
        .frame_done (fd1),
        .spi_sclk   (sclk1),
        .spi_mosi   (mosi1),
        .spi_cs_n   (csn1)
    );

    // Pin monitor: one HCLK sample per negedge.
    logic m_sclk [2];
    logic m_cs   [2];
    logic m_mosi [2];
    logic m_fd   [2];
    logic m_ovf  [2];

    assign m_sclk[0] = sclk0;
    assign m_sclk[1] = sclk1;
    assign m_cs[0]   = csn0;
    assign m_cs[1]   = csn1;
    assign m_mosi[0] = mosi0;
    assign m_mosi[1] = mosi1;
    assign m_fd[0]   = fd0;
    assign m_fd[1]   = fd1;
    assign m_ovf[0]  = ovf0;
    assign m_ovf[1]  = ovf1;

    int          lowlen  [2] = '{0, 0};
    int          highlen [2] = '{0, 0};
    int          nbits   [2] = '{0, 0};
    int          stalls  [2] = '{0, 0};
    int          fd_cnt  [2] = '{0, 0};
    int          fd_bad  [2] = '{0, 0};
    int          ovf_cnt [2] = '{0, 0};
    logic [23:0] sh      [2] = '{24'h0, 24'h0};
    logic        pscl    [2] = '{1'b0, 1'b0};
    logic        pcs     [2] = '{1'b1, 1'b1};
    bit          seen    [2] = '{1'b0, 1'b0};

    frame_t fq0 [$];
    frame_t fq1 [$];
    int     gq0 [$];
    int     gq1 [$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_fd[i] === 1'b1) begin
                fd_cnt[i]++;
                if (m_cs[i] !== 1'b1) fd_bad[i]++;
            end
            if (m_ovf[i] === 1'b1) ovf_cnt[i]++;
            if (m_cs[i] === 1'b0) begin
                if (pcs[i] === 1'b1) begin
                    if (seen[i]) begin
                        if (i == 0) gq0.push_back(highlen[i]);
                        else gq1.push_back(highlen[i]);
                    end
                    lowlen[i] = 0;
                    nbits[i]  = 0;
                    sh[i]     = '0;
                end
                lowlen[i]++;
                if (pcs[i] === 1'b0 && m_sclk[i] === pscl[i]) stalls[i]++;
                if (m_sclk[i] === 1'b1 && pscl[i] === 1'b0) begin
                    sh[i] = {sh[i][22:0], m_mosi[i]};
                    nbits[i]++;
                end
            end else begin
                if (pcs[i] === 1'b0) begin
                    if (i == 0) fq0.push_back('{sh[i], nbits[i], lowlen[i]});
                    else fq1.push_back('{sh[i], nbits[i], lowlen[i]});
                    seen[i]    = 1'b1;
                    highlen[i] = 0;
                end
                highlen[i]++;
            end
            pscl[i] = m_sclk[i];
            pcs[i]  = m_cs[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        fq0.delete();
        fq1.delete();
        gq0.delete();
        gq1.delete();
        for (int i = 0; i < 2; i++) begin
            seen[i]    = 1'b0;
            stalls[i]  = 0;
            fd_cnt[i]  = 0;
            fd_bad[i]  = 0;
            ovf_cnt[i] = 0;
        end
    endtask

    task automatic wait_frames(input int dut, input int n, input int maxc);
        int c;
        int sz;
        c  = 0;
        sz = (dut == 0) ? fq0.size() : fq1.size();
        while (sz < n && c < maxc) begin
            @(posedge clk);
            #1;
            c++;
            sz = (dut == 0) ? fq0.size() : fq1.size();
        end
        check("frame_count", sz, n);
    endtask

    task automatic wait_idle0(input int maxc);
        int c;
        c = 0;
        @(posedge clk);
        #1;
        while (!(empty0 === 1'b1 && busy0 === 1'b0) && c < maxc) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("idle_reached", (c < maxc), 1);
    endtask

    task automatic chk_frame(input int dut, input int idx,
                             input logic [23:0] exp, input int explen);
        frame_t f;
        int     sz;
        sz = (dut == 0) ? fq0.size() : fq1.size();
        if (idx < sz) begin
            f = (dut == 0) ? fq0[idx] : fq1[idx];
            check($sformatf("frame%0d_%0d_data", dut, idx), f.data, exp);
            check($sformatf("frame%0d_%0d_bits", dut, idx), f.nbits, 24);
            check($sformatf("frame%0d_%0d_len", dut, idx), f.len, explen);
        end else begin
            check($sformatf("frame%0d_%0d_present", dut, idx), sz, idx + 1);
        end
    endtask

    vec_t        b2b [4];
    vec_t        six [6];
    logic [23:0] fillw [5];

    initial begin
        int c;

        b2b[0] = '{24'h000001, 1'b0, 1'b0};
        b2b[1] = '{24'h800000, 1'b0, 1'b0};
        b2b[2] = '{24'hFFFFFF, 1'b0, 1'b0};
        b2b[3] = '{24'h000000, 1'b0, 1'b0};

        six[0] = '{24'h100001, 1'b0, 1'b0};
        six[1] = '{24'h200002, 1'b0, 1'b0};
        six[2] = '{24'h300003, 1'b0, 1'b0};
        six[3] = '{24'h400004, 1'b0, 1'b0};
        six[4] = '{24'h500005, 1'b1, 1'b0};
        six[5] = '{24'h600006, 1'b1, 1'b1};

        fillw[0] = 24'h111111;
        fillw[1] = 24'h222222;
        fillw[2] = 24'h333333;
        fillw[3] = 24'h444444;
        fillw[4] = 24'h555555;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", csn0, 1'b1);
        check("rst_sclk", sclk0, 1'b0);
        check("rst_mosi", mosi0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_full", full0, 1'b0);
        check("rst_empty", empty0, 1'b1);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_fd", fd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();

        // Single word, latency and frame shape
        @(negedge clk);
        tx_en0 = 1'b1;
        data0  = 24'hA5C3F0;
        @(posedge clk);
        #1;
        check("lat_cs_hi_c1", csn0, 1'b1);
        check("lat_busy_c1", busy0, 1'b0);
        check("lat_empty_c1", empty0, 1'b0);
        @(negedge clk);
        tx_en0 = 1'b0;
        @(posedge clk);
        #1;
        check("lat_cs_lo_c2", csn0, 1'b0);
        check("lat_busy_c2", busy0, 1'b1);
        check("lat_empty_c2", empty0, 1'b1);
        wait_frames(0, 1, 400);
        chk_frame(0, 0, 24'b1010_0101_1100_0011_1111_0000, 196);
        wait_idle0(50);
        check("single_fd_cnt", fd_cnt[0], 1);
        check("single_fd_cs", fd_bad[0], 0);
        clear_mon();

        // Four back-to-back words
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tx_en0 = 1'b1;
            data0  = b2b[k].data;
            @(posedge clk);
            #1;
            check($sformatf("b2b_full_%0d", k), full0, b2b[k].full);
            check($sformatf("b2b_ovf_%0d", k), ovf0, b2b[k].ovf);
        end
        @(negedge clk);
        tx_en0 = 1'b0;
        wait_frames(0, 4, 1000);
        for (int k = 0; k < 4; k++) chk_frame(0, k, b2b[k].data, 196);
        check("b2b_gap_count", gq0.size(), 3);
        for (int k = 0; k < gq0.size(); k++)
            check($sformatf("b2b_gap_%0d", k), gq0[k], 3);
        wait_idle0(50);
        check("b2b_no_ovf", ovf_cnt[0], 0);
        check("b2b_fd_cnt", fd_cnt[0], 4);
        clear_mon();

        // Six strobes while idle: sixth is dropped
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tx_en0 = 1'b1;
            data0  = six[k].data;
            @(posedge clk);
            #1;
            check($sformatf("six_full_%0d", k), full0, six[k].full);
            check($sformatf("six_ovf_%0d", k), ovf0, six[k].ovf);
        end
        @(negedge clk);
        tx_en0 = 1'b0;
        @(posedge clk);
        #1;
        check("six_ovf_pulse_end", ovf0, 1'b0);
        check("six_full_hold", full0, 1'b1);
        wait_frames(0, 5, 1300);
        for (int k = 0; k < 5; k++) chk_frame(0, k, six[k].data, 196);
        wait_idle0(300);
        check("six_ovf_cnt", ovf_cnt[0], 1);
        check("six_frames_total", fq0.size(), 5);
        clear_mon();

        // Full FIFO, push lands on the IDLE pop cycle
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tx_en0 = 1'b1;
            data0  = fillw[k];
        end
        @(negedge clk);
        tx_en0 = 1'b0;
        check("pp_full_before", full0, 1'b1);
        c = 0;
        while (busy0 !== 1'b0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("pp_idle_seen", (c < 400), 1);
        tx_en0 = 1'b1;
        data0  = 24'hABCDEF;
        @(posedge clk);
        #1;
        check("pp_full_after", full0, 1'b1);
        check("pp_no_ovf", ovf0, 1'b0);
        check("pp_busy", busy0, 1'b1);
        @(negedge clk);
        tx_en0 = 1'b0;
        wait_frames(0, 6, 1500);
        for (int k = 0; k < 5; k++) chk_frame(0, k, fillw[k], 196);
        chk_frame(0, 5, 24'hABCDEF, 196);
        wait_idle0(50);
        check("pp_ovf_cnt", ovf_cnt[0], 0);
        clear_mon();

        // Reset mid high phase of bit 10
        @(negedge clk);
        tx_en0 = 1'b1;
        data0  = 24'h123456;
        @(negedge clk);
        data0  = 24'h654321;
        @(negedge clk);
        tx_en0 = 1'b0;
        c = 0;
        while (!(nbits[0] == 14 && sclk0 === 1'b1) && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("rm_bit10_reached", (c < 300), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rm_cs_n", csn0, 1'b1);
        check("rm_sclk", sclk0, 1'b0);
        check("rm_empty", empty0, 1'b1);
        check("rm_busy", busy0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_mon();
        @(negedge clk);
        tx_en0 = 1'b1;
        data0  = 24'h3C5A96;
        @(negedge clk);
        tx_en0 = 1'b0;
        wait_frames(0, 1, 400);
        chk_frame(0, 0, 24'h3C5A96, 196);
        wait_idle0(50);
        repeat (10) @(posedge clk);
        #1;
        check("rm_flushed_busy", busy0, 1'b0);
        check("rm_flushed_frames", fq0.size(), 1);
        clear_mon();

        // CLK_DIV=1, CS_GAP=1 instance
        @(negedge clk);
        tx_en1 = 1'b1;
        data1  = 24'h5AA55A;
        @(negedge clk);
        tx_en1 = 1'b0;
        wait_frames(1, 1, 100);
        chk_frame(1, 0, 24'h5AA55A, 49);
        repeat (4) @(posedge clk);
        #1;
        check("div1_sclk_toggle", stalls[1], 0);
        check("div1_fd_cnt", fd_cnt[1], 1);
        check("div1_idle", busy1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
